// File: rtl/code_lock.sv
// code_lock: sequence-detecting lock with a run-time programmable code.
// Accepts CODE_LEN symbols per entry, raises `unlock` for HOLD_CYCLES on a
// match and pulses `fail` on a wrong entry. Partial entries are abandoned
// after ENTRY_TIMEOUT idle cycles (0 disables the timeout).
// Optional feature macro: CODE_LOCK_LOCKOUT_EN. When defined, MAX_FAIL
// consecutive wrong entries force a LOCKOUT period of LOCKOUT_CYCLES.
//
// Symbol handshake: a symbol is consumed on every rising edge where
// sym_valid is high and the lock is in LOCKED; there is no ready signal,
// symbols offered in UNLOCKED or LOCKOUT are dropped.
module code_lock #(
    parameter int SYM_W          = 2,
    parameter int CODE_LEN       = 4,
    parameter logic [CODE_LEN*SYM_W-1:0] DEFAULT_CODE = 8'hB4,
    parameter int HOLD_CYCLES    = 8,
    parameter int ENTRY_TIMEOUT  = 16,
    parameter int MAX_FAIL       = 3,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sym_valid,
    input  logic [SYM_W-1:0]          sym,
    input  logic                      relock,
    input  logic                      prog_en,
    input  logic [CODE_LEN*SYM_W-1:0] code_in,
    output logic                      unlock,
    output logic                      fail,
    output logic                      locked_out,
    output logic                      busy
);

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_LOCKOUT  = 2'd2
    } state_t;

    localparam int IDX_W   = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int TMR_MAX = (HOLD_CYCLES > LOCKOUT_CYCLES) ? HOLD_CYCLES : LOCKOUT_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int IDLE_W  = (ENTRY_TIMEOUT > 0) ? $clog2(ENTRY_TIMEOUT + 1) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(CODE_LEN - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = (ENTRY_TIMEOUT > 0) ? IDLE_W'(ENTRY_TIMEOUT - 1) : '0;

    // Reject nonsensical parameter sets at elaboration.
    if (SYM_W < 1 || CODE_LEN < 1 || HOLD_CYCLES < 1 || MAX_FAIL < 1 ||
        LOCKOUT_CYCLES < 1 || ENTRY_TIMEOUT < 0) begin : g_param_check
        $error("code_lock: illegal parameter value");
    end

    state_t                      state;
    logic [IDX_W-1:0]            idx;
    logic                        err;
    logic [TMR_W-1:0]            timer;
    logic [IDLE_W-1:0]           idle_cnt;
    logic [CODE_LEN*SYM_W-1:0]   code;
    logic [SYM_W-1:0]            code_sym;

`ifdef CODE_LOCK_LOCKOUT_EN
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);
    localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_FAIL - 1);
    logic [FAIL_W-1:0]           fail_cnt;
`endif

    // Expected symbol for the current entry position.
    assign code_sym = code[idx*SYM_W +: SYM_W];

    // Main lock FSM: entry tracking, hold/lockout timing, code programming.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_LOCKED;
            idx      <= '0;
            err      <= 1'b0;
            timer    <= '0;
            idle_cnt <= '0;
            code     <= DEFAULT_CODE;
            fail     <= 1'b0;
`ifdef CODE_LOCK_LOCKOUT_EN
            fail_cnt <= '0;
`endif
        end else begin
            fail <= 1'b0;
            case (state)
                ST_LOCKED: begin
                    if (sym_valid) begin
                        idle_cnt <= '0;
                        if (idx == LAST_IDX) begin
                            // Entry complete: decide only now, never mid-entry.
                            idx <= '0;
                            err <= 1'b0;
                            if (!err && (sym == code_sym)) begin
                                state <= ST_UNLOCKED;
                                timer <= TMR_W'(HOLD_CYCLES);
`ifdef CODE_LOCK_LOCKOUT_EN
                                fail_cnt <= '0;
`endif
                            end else begin
                                fail <= 1'b1;
`ifdef CODE_LOCK_LOCKOUT_EN
                                if (fail_cnt == FAIL_LAST) begin
                                    state    <= ST_LOCKOUT;
                                    timer    <= TMR_W'(LOCKOUT_CYCLES);
                                    fail_cnt <= '0;
                                end else begin
                                    fail_cnt <= fail_cnt + 1'b1;
                                end
`endif
                            end
                        end else begin
                            err <= err | (sym != code_sym);
                            idx <= idx + 1'b1;
                        end
                    end else if ((idx != '0) && (ENTRY_TIMEOUT != 0)) begin
                        // Abandon a stalled partial entry silently.
                        if (idle_cnt == IDLE_LAST) begin
                            idx      <= '0;
                            err      <= 1'b0;
                            idle_cnt <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                end
                ST_UNLOCKED: begin
                    if (prog_en) begin
                        code  <= code_in;
                        state <= ST_LOCKED;
                        timer <= '0;
                    end else if (relock) begin
                        state <= ST_LOCKED;
                        timer <= '0;
                    end else if (timer <= TMR_W'(1)) begin
                        state <= ST_LOCKED;
                        timer <= '0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
`ifdef CODE_LOCK_LOCKOUT_EN
                ST_LOCKOUT: begin
                    if (timer <= TMR_W'(1)) begin
                        state <= ST_LOCKED;
                        idx   <= '0;
                        err   <= 1'b0;
                        timer <= '0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
`endif
                default: begin
                    state <= ST_LOCKED;
                    idx   <= '0;
                    err   <= 1'b0;
                    timer <= '0;
                end
            endcase
        end
    end

    assign unlock = (state == ST_UNLOCKED);
    assign busy   = (idx != '0);
`ifdef CODE_LOCK_LOCKOUT_EN
    assign locked_out = (state == ST_LOCKOUT);
`else
    assign locked_out = 1'b0;
`endif

endmodule

// File: tb/tb_code_lock.sv
// tb_code_lock: directed and random stimulus for code_lock with a
// cycle-level reference model feeding an expected-output queue.
module tb_code_lock;

    localparam int SYM_W    = 2;
    localparam int CODE_LEN = 4;
    localparam int HOLD     = 8;
    localparam int TIMEOUT  = 16;
    localparam int MAX_FAIL = 3;
    localparam int LOCKOUT  = 16;
    localparam int W        = 4;

`ifdef CODE_LOCK_LOCKOUT_EN
    localparam int LO_EXP     = 16;
    localparam int UL_WIN_EXP = 0;
`else
    localparam int LO_EXP     = 0;
    localparam int UL_WIN_EXP = 8;
`endif

    logic       clk;
    logic       reset;
    logic       sym_valid;
    logic [1:0] sym;
    logic       relock;
    logic       prog_en;
    logic [7:0] code_in;
    logic       unlock;
    logic       fail;
    logic       locked_out;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_unlock = 0;
    int n_fail   = 0;
    int n_lo     = 0;
    string tag   = "init";

    logic [W-1:0] exp_q[$];

    // Reference model state
    int         m_state;   // 0 locked, 1 unlocked, 2 lockout
    logic [1:0] m_buf[$];
    int         m_idle;
    int         m_fails;
    int         m_timer;
    logic [7:0] m_code;
    logic       m_fail;

    code_lock #(
        .SYM_W(SYM_W), .CODE_LEN(CODE_LEN), .DEFAULT_CODE(8'hB4),
        .HOLD_CYCLES(HOLD), .ENTRY_TIMEOUT(TIMEOUT),
        .MAX_FAIL(MAX_FAIL), .LOCKOUT_CYCLES(LOCKOUT)
    ) dut (
        .clk(clk), .reset(reset), .sym_valid(sym_valid), .sym(sym),
        .relock(relock), .prog_en(prog_en), .code_in(code_in),
        .unlock(unlock), .fail(fail), .locked_out(locked_out), .busy(busy)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_step(input logic sv, input logic [1:0] s, input logic rl,
                              input logic pe, input logic [7:0] ci, input logic rst);
        logic hit;
        if (rst) begin
            m_state = 0; m_buf.delete(); m_idle = 0; m_fails = 0;
            m_timer = 0; m_code = 8'hB4; m_fail = 1'b0;
        end else begin
            m_fail = 1'b0;
            case (m_state)
                0: begin
                    if (sv) begin
                        m_idle = 0;
                        m_buf.push_back(s);
                        if (m_buf.size() == CODE_LEN) begin
                            hit = 1'b1;
                            for (int k = 0; k < CODE_LEN; k++)
                                if (m_buf[k] != m_code[k*SYM_W +: SYM_W]) hit = 1'b0;
                            m_buf.delete();
                            if (hit) begin
                                m_state = 1; m_timer = HOLD; m_fails = 0;
                            end else begin
                                m_fail = 1'b1;
                                m_fails++;
`ifdef CODE_LOCK_LOCKOUT_EN
                                if (m_fails == MAX_FAIL) begin
                                    m_state = 2; m_timer = LOCKOUT; m_fails = 0;
                                end
`endif
                            end
                        end
                    end else if (m_buf.size() != 0) begin
                        m_idle++;
                        if (m_idle == TIMEOUT) begin
                            m_buf.delete(); m_idle = 0;
                        end
                    end
                end
                1: begin
                    if (pe) begin
                        m_code = ci; m_state = 0;
                    end else if (rl || m_timer == 1) begin
                        m_state = 0;
                    end else begin
                        m_timer--;
                    end
                end
                default: begin
                    if (m_timer == 1) m_state = 0;
                    else m_timer--;
                end
            endcase
        end
    endtask

    // Drive one cycle, predict, then compare after the edge.
    task automatic cycle(input logic sv, input logic [1:0] s, input logic rl,
                         input logic pe, input logic [7:0] ci, input logic rst);
        logic [W-1:0] exp_v;
        logic [W-1:0] obs_v;
        reset = rst; sym_valid = sv; sym = s; relock = rl; prog_en = pe; code_in = ci;
        model_step(sv, s, rl, pe, ci, rst);
        exp_q.push_back({m_state == 1, m_fail, m_state == 2, m_buf.size() != 0});
        @(posedge clk);
        #1;
        cyc++;
        obs_v = {unlock, fail, locked_out, busy};
        exp_v = exp_q.pop_front();
        checks++;
        assert (obs_v === exp_v) else begin
            failures++;
            $error("FAIL %s cyc=%0d {unlock,fail,locked_out,busy} observed=%b expected=%b",
                   tag, cyc, obs_v, exp_v);
        end
        if (unlock)     n_unlock++;
        if (fail)       n_fail++;
        if (locked_out) n_lo++;
    endtask

    task automatic check_eq(input string name, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", name, obs, exp_v);
        end
    endtask

    task automatic send(input logic [1:0] s);
        cycle(1'b1, s, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic entry(input logic [1:0] a, input logic [1:0] b,
                         input logic [1:0] c, input logic [1:0] d);
        send(a); send(b); send(c); send(d);
    endtask

    task automatic do_reset();
        cycle(1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic clear_counts();
        n_unlock = 0; n_fail = 0; n_lo = 0;
    endtask

    initial begin
        reset = 1'b1; sym_valid = 1'b0; sym = '0; relock = 1'b0;
        prog_en = 1'b0; code_in = '0;
        model_step(1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b1);

        tag = "reset";
        do_reset();
        do_reset();
        check_eq("reset_outputs", int'({unlock, fail, locked_out, busy}), 0);

        tag = "correct_entry";
        clear_counts();
        entry(2'd0, 2'd1, 2'd3, 2'd2);
        idle(10);
        check_eq("hold_cycles", n_unlock, HOLD);
        check_eq("hold_no_fail", n_fail, 0);

        tag = "wrong_entry";
        clear_counts();
        entry(2'd0, 2'd2, 2'd3, 2'd2);
        idle(3);
        check_eq("wrong_fail_pulses", n_fail, 1);
        check_eq("wrong_no_unlock", n_unlock, 0);

        tag = "lockout";
        do_reset();
        clear_counts();
        entry(2'd1, 2'd1, 2'd1, 2'd1);
        entry(2'd2, 2'd2, 2'd2, 2'd2);
        entry(2'd0, 2'd1, 2'd3, 2'd3);
        entry(2'd0, 2'd1, 2'd3, 2'd2);
        idle(14);
        check_eq("lockout_cycles", n_lo, LO_EXP);
        check_eq("lockout_fails", n_fail, 3);
        check_eq("lockout_entry_ignored", n_unlock, UL_WIN_EXP);
        entry(2'd0, 2'd1, 2'd3, 2'd2);
        idle(10);
        check_eq("after_lockout_unlock", n_unlock, UL_WIN_EXP + HOLD);

        tag = "timeout";
        do_reset();
        clear_counts();
        send(2'd0); send(2'd1);
        idle(15);
        check_eq("timeout_busy_before", int'(busy), 1);
        idle(1);
        check_eq("timeout_busy_after", int'(busy), 0);
        send(2'd3); send(2'd2);
        idle(20);
        check_eq("timeout_no_fail", n_fail, 0);
        entry(2'd0, 2'd1, 2'd3, 2'd2);
        idle(2);
        tag = "relock";
        cycle(1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 1'b0);
        check_eq("relock_unlock_low", int'(unlock), 0);
        idle(2);
        check_eq("relock_unlock_count", n_unlock, 3);

        tag = "program";
        clear_counts();
        entry(2'd0, 2'd1, 2'd3, 2'd2);
        idle(1);
        cycle(1'b0, 2'd0, 1'b0, 1'b1, 8'h1B, 1'b0);
        check_eq("prog_unlock_low", int'(unlock), 0);
        entry(2'd0, 2'd1, 2'd3, 2'd2);
        idle(2);
        check_eq("prog_old_code_fails", n_fail, 1);
        entry(2'd3, 2'd2, 2'd1, 2'd0);
        idle(10);
        check_eq("prog_new_code_unlocks", n_unlock, 2 + HOLD);

        tag = "reset_mid";
        clear_counts();
        send(2'd0); send(2'd1);
        do_reset();
        check_eq("reset_mid_entry", int'({unlock, fail, locked_out, busy}), 0);
        entry(2'd3, 2'd2, 2'd1, 2'd0);
        idle(2);
        entry(2'd0, 2'd1, 2'd3, 2'd2);
        idle(3);
        do_reset();
        check_eq("reset_mid_hold", int'({unlock, fail, locked_out, busy}), 0);
        entry(2'd0, 2'd1, 2'd3, 2'd2);
        idle(10);
        check_eq("reset_code_default", n_fail, 1);

        tag = "random";
        for (int i = 0; i < 400; i++) begin
            logic       r_sv;
            logic [1:0] r_sym;
            logic       r_rl;
            logic       r_pe;
            logic       r_rst;
            r_sv  = logic'($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0 || m_buf.size() >= CODE_LEN)
                r_sym = 2'($urandom_range(0, 3));
            else
                r_sym = m_code[m_buf.size()*SYM_W +: SYM_W];
            r_rl  = logic'($urandom_range(0, 15) == 0);
            r_pe  = logic'($urandom_range(0, 31) == 0);
            r_rst = logic'($urandom_range(0, 127) == 0);
            cycle(r_sv, r_sym, r_rl, r_pe, 8'($urandom_range(0, 255)), r_rst);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
